stopwatch_core: RTL
===================

# stopwatch_core

Parametrised stopwatch engine with integrated display scanning. It is the next generation of the team's fixed four-digit MM:SS stopwatch top level. It adds a configurable digit count, count-down mode with an expiry stop, lap freeze and per-field adjust with blinking. It sits between the debounced/synchronised button inputs and the multiplexed seven-segment display pins.

## Interface
- DIGITS, 4: display digits; even, 2..8; grouped into DIGITS/2 two-digit fields (field 0 = rightmost).
- TICK_DIV, 100_000_000: clk cycles per count tick.
- ADJ_DIV, 50_000_000: clk cycles per adjust step.
- SCAN_DIV, 100_000: clk cycles each digit is driven.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; reset=0 sampled at a clk edge resets everything.
- pause  in  1  level, debounced; each 0→1 edge toggles run/pause.
- lap  in  1  level, debounced; each 0→1 edge toggles display freeze.
- adjust  in  1  level; high = adjust mode.
- select  in  max(1,$clog2(DIGITS/2))  field to adjust.
- down  in  1  1 = count down, 0 = count up.
- disNum  out  7  active-low segments {g,f,e,d,c,b,a}.
- select_digit  out  DIGITS  active-low one-hot digit enable; bit 0 = rightmost.
- running  out  1  high in RUN.
- wrap  out  1  one-cycle pulse on wrap (up) or expiry (down).

## Operation
- Field radices:
  - Field 0 (seconds): mod 60.
  - Field 1 (minutes): mod 60.
  - Fields ≥2: mod 100.
  - Digits are stored BCD.
- Reset values:
  - State PAUSED; count all zero.
  - Prescaler, scan and blink counters at 0; lap freeze off.
  - running=0, wrap=0.
  - select_digit = all ones except bit 0 = 0; disNum = 7'h40 ("0").
- States:
  - PAUSED → RUN on a pause edge.
  - RUN → PAUSED on a pause edge.
  - ADJUST is entered from any state while adjust=1. It clears the tick prescaler and lap freeze. When adjust falls, the block goes to PAUSED.
  - Pause and lap edges are ignored in ADJUST.
- RUN, up mode, on each tick:
  - BCD increment with carry across fields.
  - All fields at their maximum → all zero, wrap pulse, stay in RUN.
- RUN, down mode, on each tick:
  - Decrement with borrow.
  - The tick that reaches all zero pulses wrap and forces PAUSED.
  - A pause edge while the count is already zero in down mode enters RUN, but no tick changes the count, and the next tick pulses wrap and returns to PAUSED.
- ADJUST:
  - Field `select` steps every ADJ_DIV cycles: +1 when down=0, −1 when down=1, modulo its radix.
  - No carry or borrow into other fields.
  - Out-of-range select values are ignored (no field steps).
- Prescaler behaviour: the tick prescaler holds its value in PAUSED.
- Lap:
  - An edge while frozen=0 snapshots the count to a display register; counting continues.
  - The next edge releases the freeze.
- Simultaneous events:
  - Pause and lap edges in the same cycle are both honoured.
  - A tick and a pause edge in the same cycle: the tick applies, then the state toggles.
  - reset=0 overrides everything.
- Display:
  - The scan index advances round-robin 0..DIGITS-1 every SCAN_DIV cycles.
  - In ADJUST, both digits of the selected field show 7'h7F during the off half of the blink (blink starts on, at ADJUST entry).

## Timing
- Pause edge detection: pause=0 sampled at edge t−1 and 1 at edge t → running changes after edge t+1.
- Tick cadence:
  - A tick fires when the prescaler equals TICK_DIV−1.
  - The count update is visible the cycle after the tick.
  - wrap is asserted in the same cycle the updated count appears.
- Display outputs:
  - disNum and select_digit are registered and change together.
  - Latency is one cycle after a scan index or count change.
- Reset timing: reset mid-operation takes effect at the next clk edge with no partial state.

## Structure
- Shared package/include stopwatch_defs:
  - State encoding (PAUSED, RUN, ADJUST).
  - Segment constants for 0–9 and blank.
  - Field radix constants.
  - BCD-to-segment function.
- Sub-module sevenseg_scan:
  - Inputs: the DIGITS×4 BCD bus and a per-digit blank mask.
  - Owns the scan counter and registered disNum/select_digit.
- The core keeps the FSM, edge detectors, prescalers, BCD counter chain and lap register.

## Test plan
Parameters: DIGITS=4, TICK_DIV=4, ADJ_DIV=2, SCAN_DIV=2, BLINK_DIV=8.
- Reset low 3 cycles → running=0, wrap=0, select_digit=4'b1110, disNum=7'h40; scan then visits 1101, 1011, 0111 every 2 cycles.
- Pause edge, then 240 cycles of RUN → count 01:00; seconds 59→00 carries into minutes; a second pause edge freezes the count.
- Adjust to 59:59, release adjust, pause edge, one tick → 00:00, wrap high exactly 1 cycle, running stays 1.
- down=1 from 00:02, run → 00:01, then 00:00 with wrap pulse, running=0 on the same cycle as the 00:00 update.
- adjust=1 with select=1 from 59:xx → one step gives 00:xx with seconds unchanged; digits 2–3 blank for 8 cycles in each 16; pause edges ignored.
- Lap edge during RUN → display holds the snapshot while the count advances; a second edge shows the live count; reset=0 for one cycle mid-run → all reset values.

Source files
------------

// File: rtl/stopwatch_core_pkg.sv
// stopwatch_core_pkg: state encoding, segment table, field radices and BCD helpers
package stopwatch_core_pkg;
   localparam logic [1:0] ST_PAUSED = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_ADJUST = 2'd2;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   // Active-low {g,f,e,d,c,b,a} patterns, digit 9 in the top slot
   localparam logic [69:0] SEG_TAB = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                      7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
   localparam int RADIX_LO = 60;
   localparam int RADIX_HI = 100;

   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      return d > 4'd9 ? SEG_BLANK : SEG_TAB[int'(d) * 7 +: 7];
   endfunction

   function automatic logic [3:0] fld_max(input int f);
      return 4'((f < 2 ? RADIX_LO : RADIX_HI) / 10 - 1);
   endfunction

   function automatic logic [7:0] fld_inc(input logic [7:0] v, input logic [3:0] mt);
      return v == {mt, 4'd9} ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
   endfunction

   function automatic logic [7:0] fld_dec(input logic [7:0] v, input logic [3:0] mt);
      return v == 8'h00 ? {mt, 4'd9} : v[3:0] == 4'd0 ? {v[7:4] - 4'd1, 4'd9} : v - 8'd1;
   endfunction
endpackage

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: button/mode inputs and display outputs of the stopwatch core
interface stopwatch_core_if #(
   parameter int DIGITS = 4
);
   localparam int SEL_W = DIGITS > 2 ? $clog2(DIGITS / 2) : 1;
   logic              pause_i;
   logic              lap_i;
   logic              adjust_i;
   logic [SEL_W-1:0]  select_i;
   logic              down_i;
   logic [6:0]        dis_num_o;
   logic [DIGITS-1:0] select_digit_o;
   logic              running_o;
   logic              wrap_o;
   modport master (
      output pause_i, lap_i, adjust_i, select_i, down_i,
      input  dis_num_o, select_digit_o, running_o, wrap_o
   );
   modport slave (
      input  pause_i, lap_i, adjust_i, select_i, down_i,
      output dis_num_o, select_digit_o, running_o, wrap_o
   );
endinterface

// File: rtl/stopwatch_core_sevenseg_scan.sv
// sevenseg_scan: round-robin digit scanner with registered segment and digit-enable outputs
module sevenseg_scan
   import stopwatch_core_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 100_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DIGITS*4-1:0] bcd_i,
   input  logic [DIGITS-1:0]   blank_i,
   output logic [6:0]          dis_num_o,
   output logic [DIGITS-1:0]   select_digit_o
);
   localparam int SW = $clog2(SCAN_DIV + 1);
   localparam int IW = $clog2(DIGITS);
   localparam logic [SW-1:0] SC_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IX_MAX = IW'(DIGITS - 1);
   logic [SW-1:0]     sc_q, sc_d;
   logic [IW-1:0]     ix_q, ix_d;
   logic [6:0]        seg_q, seg_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   always_comb begin
      sc_d  = sc_q == SC_MAX ? '0 : sc_q + SW'(1);
      ix_d  = sc_q != SC_MAX ? ix_q : ix_q == IX_MAX ? '0 : ix_q + IW'(1);
      seg_d = blank_i[ix_q] ? SEG_BLANK : bcd_to_seg(bcd_i[ix_q * 4 +: 4]);
      sel_d = ~(DIGITS'(1) << ix_q);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         sc_q  <= '0;
         ix_q  <= '0;
         seg_q <= SEG_0;
         sel_q <= ~DIGITS'(1);
      end else begin
         sc_q  <= sc_d;
         ix_q  <= ix_d;
         seg_q <= seg_d;
         sel_q <= sel_d;
      end
   end
   assign dis_num_o      = seg_q;
   assign select_digit_o = sel_q;
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch/timer with lap freeze, per-field adjust and multiplexed display
module stopwatch_core
   import stopwatch_core_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int TICK_DIV  = 100_000_000,
   parameter int ADJ_DIV   = 50_000_000,
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input logic             clk,
   input logic             reset,
   stopwatch_core_if.slave sw
);
   localparam int FIELDS = DIGITS / 2;
   localparam int W      = DIGITS * 4;
   localparam int PW     = $clog2(TICK_DIV + 1);
   localparam int AW     = $clog2(ADJ_DIV + 1);
   localparam int BW     = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ADJ_MAX = AW'(ADJ_DIV - 1);
   localparam logic [BW-1:0] BL_MAX  = BW'(BLINK_DIV - 1);
   logic [1:0]        st_q, st_d, st_t, p_q, l_q;
   logic [W-1:0]      cnt_q, cnt_d, lap_q, lap_d, inc, dec, adj, disp;
   logic [PW-1:0]     pre_q, pre_d;
   logic [AW-1:0]     adj_q, adj_d;
   logic [BW-1:0]     bl_q, bl_d;
   logic              off_q, off_d, frz_q, frz_d, wrap_q, wrap_d;
   logic              cy, bw, adj_mode, adj_on, pe, le, tick, step, expire;
   logic [DIGITS-1:0] blank;
   // Carry/borrow chains for counting plus the carry-free single-field adjust
   always_comb begin
      inc   = cnt_q;
      dec   = cnt_q;
      adj   = cnt_q;
      blank = '0;
      cy    = 1'b1;
      bw    = 1'b1;
      for (int f = 0; f < FIELDS; f++) begin
         if (cy) begin
            inc[f*8 +: 8] = fld_inc(cnt_q[f*8 +: 8], fld_max(f));
            cy            = cnt_q[f*8 +: 8] == {fld_max(f), 4'd9};
         end
         if (bw) begin
            dec[f*8 +: 8] = fld_dec(cnt_q[f*8 +: 8], fld_max(f));
            bw            = cnt_q[f*8 +: 8] == 8'h00;
         end
         if (int'(sw.select_i) == f) begin
            adj[f*8 +: 8]   = sw.down_i ? fld_dec(cnt_q[f*8 +: 8], fld_max(f)) : fld_inc(cnt_q[f*8 +: 8], fld_max(f));
            blank[f*2 +: 2] = {2{st_q == ST_ADJUST && off_q}};
         end
      end
   end
   always_comb begin
      adj_mode = sw.adjust_i || st_q == ST_ADJUST;
      adj_on   = sw.adjust_i && st_q == ST_ADJUST;
      pe       = p_q[0] && !p_q[1] && !adj_mode;
      le       = l_q[0] && !l_q[1] && !adj_mode;
      tick     = st_q == ST_RUN && !sw.adjust_i && pre_q == PRE_MAX;
      step     = adj_on && adj_q == ADJ_MAX;
      expire   = cnt_q == '0 || dec == '0;
      pre_d    = sw.adjust_i || tick ? '0 : st_q == ST_RUN ? pre_q + PW'(1) : pre_q;
      adj_d    = adj_on && !step ? adj_q + AW'(1) : '0;
      bl_d     = adj_on && bl_q != BL_MAX ? bl_q + BW'(1) : '0;
      off_d    = adj_on && (off_q ^ (bl_q == BL_MAX));
      cnt_d    = tick ? (sw.down_i ? (cnt_q == '0 ? '0 : dec) : inc) : step ? adj : cnt_q;
      wrap_d   = tick && (sw.down_i ? expire : cy);
      // A same-cycle tick settles first; the pause edge then toggles the result
      st_t     = tick && sw.down_i && expire ? ST_PAUSED : st_q;
      st_d     = sw.adjust_i ? ST_ADJUST : st_q == ST_ADJUST ? ST_PAUSED :
                 pe ? (st_t == ST_RUN ? ST_PAUSED : ST_RUN) : st_t;
      frz_d    = !adj_mode && (frz_q ^ le);
      lap_d    = le && !frz_q ? cnt_q : lap_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         st_q   <= ST_PAUSED;
         cnt_q  <= '0;
         lap_q  <= '0;
         pre_q  <= '0;
         adj_q  <= '0;
         bl_q   <= '0;
         off_q  <= 1'b0;
         frz_q  <= 1'b0;
         wrap_q <= 1'b0;
         p_q    <= '0;
         l_q    <= '0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         lap_q  <= lap_d;
         pre_q  <= pre_d;
         adj_q  <= adj_d;
         bl_q   <= bl_d;
         off_q  <= off_d;
         frz_q  <= frz_d;
         wrap_q <= wrap_d;
         p_q    <= {p_q[0], sw.pause_i};
         l_q    <= {l_q[0], sw.lap_i};
      end
   end
   assign disp         = frz_q ? lap_q : cnt_q;
   assign sw.running_o = st_q == ST_RUN;
   assign sw.wrap_o    = wrap_q;
   sevenseg_scan #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk            (clk),
      .reset          (reset),
      .bcd_i          (disp),
      .blank_i        (blank),
      .dis_num_o      (sw.dis_num_o),
      .select_digit_o (sw.select_digit_o)
   );
endmodule
